pixel_serializer: RTL

PIXEL_SERIALIZER -- requirements
Module: pixel_serializer

---
 rtl/pixel_serializer_if.sv | 25 ++
 rtl/pixel_serializer.sv | 112 +++++++++++
 2 files changed

// File: rtl/pixel_serializer_if.sv
// Parallel-group input and serial-pixel output handshake bundle for pixel_serializer.
// The slave modport is the serializer side; the master modport is the source/sink side.
interface pixel_serializer_if #(
    parameter int RBG_SIZE    = 24,
    parameter int NUM_ENGINES = 12
);
    logic [NUM_ENGINES-1:0][RBG_SIZE-1:0] rgb_val;
    logic                                 in_valid;
    logic                                 in_ready;
    logic [RBG_SIZE-1:0]                  out_data;
    logic                                 out_valid;
    logic                                 out_ready;
    logic                                 out_sof;
    logic                                 out_eol;

    modport master (
        output rgb_val, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_sof, out_eol
    );

    modport slave (
        input  rgb_val, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_sof, out_eol
    );
endinterface

// File: rtl/pixel_serializer.sv
// Serializes NUM_ENGINES-wide pixel groups to one pixel per cycle with frame/line markers.
// Latency 1 cycle in->out; a stalled pixel holds, and a new group is taken only as the last pixel leaves.
module pixel_serializer #(
    parameter int RBG_SIZE     = 24,
    parameter int NUM_ENGINES  = 12,
    parameter int IMAGE_WIDTH  = 720,
    parameter int IMAGE_HEIGHT = 480
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              restart,
    pixel_serializer_if.slave bus
);
    localparam int IDX_W = (NUM_ENGINES  > 1) ? $clog2(NUM_ENGINES)  : 1;
    localparam int X_W   = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
    localparam int Y_W   = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_ENGINES - 1);
    localparam logic [X_W-1:0]   X_LAST   = X_W'(IMAGE_WIDTH - 1);
    localparam logic [Y_W-1:0]   Y_LAST   = Y_W'(IMAGE_HEIGHT - 1);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_SEND  = 1'b1;

    logic [0:0]                           state_q, state_d;
    logic [IDX_W-1:0]                     idx_q, idx_d;
    logic [X_W-1:0]                       x_q, x_d;
    logic [Y_W-1:0]                       y_q, y_d;
    logic [NUM_ENGINES-1:0][RBG_SIZE-1:0] hold_q, hold_d;
    logic                                 live_q;
    logic                                 send;
    logic                                 in_rdy;
    logic                                 in_xfer;
    logic                                 out_xfer;

    assign send = (state_q == ST_SEND);

    // live_q keeps in_ready low until the first edge after reset release
    always_comb begin
        in_rdy = 1'b0;
        if (!restart && live_q) begin
            if (state_q == ST_EMPTY) begin
                in_rdy = 1'b1;
            end else begin
                in_rdy = (idx_q == IDX_LAST) && bus.out_ready;
            end
        end
    end

    assign in_xfer  = bus.in_valid && in_rdy;
    assign out_xfer = send && bus.out_ready;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        x_d     = x_q;
        y_d     = y_q;
        hold_d  = hold_q;
        if (restart) begin
            state_d = ST_EMPTY;
            idx_d   = '0;
            x_d     = '0;
            y_d     = '0;
            hold_d  = '0;
        end else begin
            if (out_xfer) begin
                if (idx_q == IDX_LAST) begin
                    idx_d   = '0;
                    state_d = ST_EMPTY;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
                if (x_q == X_LAST) begin
                    x_d = '0;
                    y_d = (y_q == Y_LAST) ? '0 : y_q + Y_W'(1);
                end else begin
                    x_d = x_q + X_W'(1);
                end
            end
            // a group arriving with the last pixel overrides the return to EMPTY
            if (in_xfer) begin
                hold_d  = bus.rgb_val;
                idx_d   = '0;
                state_d = ST_SEND;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            idx_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            hold_q  <= '0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            x_q     <= x_d;
            y_q     <= y_d;
            hold_q  <= hold_d;
            live_q  <= 1'b1;
        end
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = send;
    assign bus.out_data  = send ? hold_q[idx_q] : '0;
    assign bus.out_sof   = send && (x_q == '0) && (y_q == '0);
    assign bus.out_eol   = send && (x_q == X_LAST);
endmodule
